// File: rtl/gfx_pkg.sv
// ----------------------------------------------------------------------------
// Module : gfx_pkg
// Desc   : Shared rasteriser front-end types, FSM encodings and vertex packing.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

// Vertex k of a packed array occupies bits [k*w +: w]; shared with edge setup.
`ifndef GFX_VSLICE
`define GFX_VSLICE(k, w) (k)*(w) +: (w)
`endif

package gfx_pkg;

  localparam int GFX_COORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sort_argbest.sv
// ----------------------------------------------------------------------------
// Module : sort_argbest
// Desc   : Combinational linear scan for the best y key in [p..N_VERT-1].
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sort_argbest
  import gfx_pkg::*;
#(
  parameter int COORD_W = GFX_COORD_W,
  parameter int N_VERT  = 3,
  parameter int IDX_W   = (N_VERT > 1) ? $clog2(N_VERT) : 1
) (
  input  logic [N_VERT*COORD_W-1:0] y,
  input  logic [N_VERT*IDX_W-1:0]   perm,
  input  logic [IDX_W-1:0]          p,
  input  logic                      desc,
  output logic [IDX_W-1:0]          sel
);

  logic [IDX_W-1:0]          w_best;
  logic signed [COORD_W-1:0] w_yk;
  logic signed [COORD_W-1:0] w_yb;
  logic                      w_better;
  logic                      w_tie;

  // Equal keys fall back to the original index, so the order is stable.
  always_comb begin
    w_best   = p;
    w_yk     = '0;
    w_yb     = '0;
    w_better = 1'b0;
    w_tie    = 1'b0;
    for (int k = 0; k < N_VERT; k++) begin
      if (k > int'(p)) begin
        w_yk     = y[`GFX_VSLICE(k, COORD_W)];
        w_yb     = y[`GFX_VSLICE(w_best, COORD_W)];
        w_better = desc ? (w_yk > w_yb) : (w_yk < w_yb);
        w_tie    = (w_yk == w_yb) &&
                   (perm[`GFX_VSLICE(k, IDX_W)] < perm[`GFX_VSLICE(w_best, IDX_W)]);
        if (w_better || w_tie) begin
          w_best = IDX_W'(k);
        end
      end
    end
  end

  assign sel = w_best;

endmodule

`default_nettype wire

// File: rtl/vertex_sort_seq.sv
// ----------------------------------------------------------------------------
// Module : vertex_sort_seq
// Desc   : Sequential selection sorter of N_VERT vertices by signed y.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module vertex_sort_seq
  import gfx_pkg::*;
#(
  parameter int COORD_W = GFX_COORD_W,
  parameter int N_VERT  = 3,
  parameter int IDX_W   = (N_VERT > 1) ? $clog2(N_VERT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_desc,
  input  logic [N_VERT*COORD_W-1:0] in_x,
  input  logic [N_VERT*COORD_W-1:0] in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_VERT*COORD_W-1:0] out_x,
  output logic [N_VERT*COORD_W-1:0] out_y,
  output logic [N_VERT*IDX_W-1:0]   out_perm,
  output logic                      out_flat,
  output logic                      busy
);

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [IDX_W-1:0]          r_p;
  logic                      r_desc;
  logic [N_VERT*COORD_W-1:0] r_x;
  logic [N_VERT*COORD_W-1:0] r_y;
  logic [N_VERT*IDX_W-1:0]   r_perm;
  logic [N_VERT*COORD_W-1:0] w_x_nxt;
  logic [N_VERT*COORD_W-1:0] w_y_nxt;
  logic [N_VERT*IDX_W-1:0]   w_perm_nxt;
  logic [N_VERT*IDX_W-1:0]   w_ident;
  logic [IDX_W-1:0]          w_sel;
  logic                      w_accept;

  for (genvar gk = 0; gk < N_VERT; gk++) begin : g_ident
    assign w_ident[`GFX_VSLICE(gk, IDX_W)] = IDX_W'(gk);
  end

  sort_argbest #(
    .COORD_W (COORD_W),
    .N_VERT  (N_VERT),
    .IDX_W   (IDX_W)
  ) u_argbest (
    .y    (r_y),
    .perm (r_perm),
    .p    (r_p),
    .desc (r_desc),
    .sel  (w_sel)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = (N_VERT == 1) ? ST_DONE : ST_SORT;
      ST_SORT: if (int'(r_p) == N_VERT - 2) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  // Swap slots p and sel; when they coincide both writes restore the original.
  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_perm_nxt = r_perm;
    w_x_nxt[`GFX_VSLICE(r_p, COORD_W)]  = r_x[`GFX_VSLICE(w_sel, COORD_W)];
    w_x_nxt[`GFX_VSLICE(w_sel, COORD_W)] = r_x[`GFX_VSLICE(r_p, COORD_W)];
    w_y_nxt[`GFX_VSLICE(r_p, COORD_W)]  = r_y[`GFX_VSLICE(w_sel, COORD_W)];
    w_y_nxt[`GFX_VSLICE(w_sel, COORD_W)] = r_y[`GFX_VSLICE(r_p, COORD_W)];
    w_perm_nxt[`GFX_VSLICE(r_p, IDX_W)]  = r_perm[`GFX_VSLICE(w_sel, IDX_W)];
    w_perm_nxt[`GFX_VSLICE(w_sel, IDX_W)] = r_perm[`GFX_VSLICE(r_p, IDX_W)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p    <= '0;
      r_desc <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_perm <= w_ident;
    end else if (w_accept) begin
      r_p    <= '0;
      r_desc <= in_desc;
      r_x    <= in_x;
      r_y    <= in_y;
      r_perm <= w_ident;
    end else if (r_state == ST_SORT) begin
      r_p    <= r_p + IDX_W'(1);
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_perm <= w_perm_nxt;
    end
  end

  assign out_x    = r_x;
  assign out_y    = r_y;
  assign out_perm = r_perm;
  assign out_flat = (r_y[`GFX_VSLICE(0, COORD_W)] == r_y[`GFX_VSLICE(N_VERT - 1, COORD_W)]);

endmodule

`default_nettype wire

// File: tb/tb_vertex_sort_seq.sv
// ----------------------------------------------------------------------------
// Module : tb_vertex_sort_seq
// Desc   : Directed table-driven bench for vertex_sort_seq at N=3, N=8 and N=1.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vertex_sort_seq;

  typedef struct packed {
    logic        desc;
    logic [47:0] x;
    logic [47:0] y;
    logic [47:0] ex;
    logic [47:0] ey;
    logic [5:0]  eperm;
    logic        eflat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        v3_in_valid, v3_in_ready, v3_in_desc, v3_out_valid, v3_out_ready;
  logic        v3_out_flat, v3_busy;
  logic [47:0] v3_in_x, v3_in_y, v3_out_x, v3_out_y;
  logic [5:0]  v3_out_perm;

  logic        v8_in_valid, v8_in_ready, v8_in_desc, v8_out_valid, v8_out_ready;
  logic        v8_out_flat, v8_busy;
  logic [95:0] v8_in_x, v8_in_y, v8_out_x, v8_out_y;
  logic [23:0] v8_out_perm;

  logic        v1_in_valid, v1_in_ready, v1_in_desc, v1_out_valid, v1_out_ready;
  logic        v1_out_flat, v1_busy;
  logic [15:0] v1_in_x, v1_in_y, v1_out_x, v1_out_y;
  logic [0:0]  v1_out_perm;

  vertex_sort_seq #(.COORD_W(16), .N_VERT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3_in_valid), .in_ready(v3_in_ready),
    .in_desc(v3_in_desc), .in_x(v3_in_x), .in_y(v3_in_y),
    .out_valid(v3_out_valid), .out_ready(v3_out_ready), .out_x(v3_out_x),
    .out_y(v3_out_y), .out_perm(v3_out_perm), .out_flat(v3_out_flat), .busy(v3_busy)
  );

  vertex_sort_seq #(.COORD_W(12), .N_VERT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_desc(v8_in_desc), .in_x(v8_in_x), .in_y(v8_in_y),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_x(v8_out_x),
    .out_y(v8_out_y), .out_perm(v8_out_perm), .out_flat(v8_out_flat), .busy(v8_busy)
  );

  vertex_sort_seq #(.COORD_W(16), .N_VERT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .in_desc(v1_in_desc), .in_x(v1_in_x), .in_y(v1_in_y),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_x(v1_out_x),
    .out_y(v1_out_y), .out_perm(v1_out_perm), .out_flat(v1_out_flat), .busy(v1_busy)
  );

  vec_t vecs[6];
  int   ys8[8]   = '{5, -1, 3, -2048, 2047, 0, 3, -1};
  int   eys8[8]  = '{-2048, -1, -1, 0, 3, 3, 5, 2047};
  int   eperm8[8] = '{3, 1, 7, 5, 2, 6, 0, 4};
  logic [95:0] exp8_x, exp8_y;
  logic [23:0] exp8_perm, ident8;
  logic [47:0] hold_y, hold_x;
  logic [5:0]  hold_perm;
  int          lat;

  function automatic logic [47:0] p3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [5:0] pp3(input int a, input int b, input int c);
    return {2'(c), 2'(b), 2'(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_v3(output int l);
    l = 1;
    while (!v3_out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run3(input vec_t v, input string tag);
    int l;
    v3_in_x = v.x; v3_in_y = v.y; v3_in_desc = v.desc; v3_in_valid = 1'b1;
    chk({tag, " in_ready"}, 128'(v3_in_ready), 128'(1));
    @(posedge clk); #1;
    v3_in_valid = 1'b0; v3_in_x = '1; v3_in_y = '1; v3_in_desc = ~v.desc;
    wait_v3(l);
    chk({tag, " latency"}, 128'(l), 128'(3));
    chk({tag, " out_y"}, 128'(v3_out_y), 128'(v.ey));
    chk({tag, " out_x"}, 128'(v3_out_x), 128'(v.ex));
    chk({tag, " out_perm"}, 128'(v3_out_perm), 128'(v.eperm));
    chk({tag, " out_flat"}, 128'(v3_out_flat), 128'(v.eflat));
    chk({tag, " busy"}, 128'(v3_busy), 128'(1));
    v3_out_ready = 1'b1;
    @(posedge clk); #1;
    v3_out_ready = 1'b0;
    chk({tag, " out_valid after ready"}, 128'(v3_out_valid), 128'(0));
    chk({tag, " in_ready after ready"}, 128'(v3_in_ready), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, p3(1, 2, 3), p3(30, -5, 12), p3(2, 3, 1), p3(-5, 12, 30), pp3(1, 2, 0), 1'b0};
    vecs[1] = '{1'b1, p3(10, 20, 30), p3(7, 7, -32768), p3(10, 20, 30), p3(7, 7, -32768), pp3(0, 1, 2), 1'b0};
    vecs[2] = '{1'b0, p3(5, 6, 7), p3(4, 4, 4), p3(5, 6, 7), p3(4, 4, 4), pp3(0, 1, 2), 1'b1};
    vecs[3] = '{1'b0, p3(1, 2, 3), p3(3, 2, 1), p3(3, 2, 1), p3(1, 2, 3), pp3(2, 1, 0), 1'b0};
    vecs[4] = '{1'b1, p3(0, 1, 2), p3(-1, 5, 5), p3(1, 2, 0), p3(5, 5, -1), pp3(1, 2, 0), 1'b0};
    vecs[5] = '{1'b0, p3(11, 22, 33), p3(3, 3, 0), p3(33, 11, 22), p3(0, 3, 3), pp3(2, 0, 1), 1'b0};

    for (int k = 0; k < 8; k++) begin
      v8_in_y[k*12 +: 12]  = 12'(ys8[k]);
      v8_in_x[k*12 +: 12]  = 12'(k * 10 + 1);
      exp8_y[k*12 +: 12]   = 12'(eys8[k]);
      exp8_x[k*12 +: 12]   = 12'(eperm8[k] * 10 + 1);
      exp8_perm[k*3 +: 3]  = 3'(eperm8[k]);
      ident8[k*3 +: 3]     = 3'(k);
    end

    rst = 1'b1;
    v3_in_valid = 0; v3_in_desc = 0; v3_in_x = '0; v3_in_y = '0; v3_out_ready = 0;
    v8_in_valid = 0; v8_in_desc = 0; v8_out_ready = 0;
    v1_in_valid = 0; v1_in_desc = 0; v1_in_x = 16'sd9; v1_in_y = -16'sd7; v1_out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset in_ready", 128'(v3_in_ready), 128'(1));
    chk("reset out_valid", 128'(v3_out_valid), 128'(0));
    chk("reset busy", 128'(v3_busy), 128'(0));
    chk("reset out_x", 128'(v3_out_x), 128'(0));
    chk("reset out_y", 128'(v3_out_y), 128'(0));
    chk("reset out_flat", 128'(v3_out_flat), 128'(1));
    chk("reset out_perm", 128'(v3_out_perm), 128'(pp3(0, 1, 2)));
    chk("reset n8 out_perm", 128'(v8_out_perm), 128'(ident8));
    chk("reset n1 out_valid", 128'(v1_out_valid), 128'(0));

    for (int i = 0; i < 6; i++) begin
      run3(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 10 cycles while a new primitive is offered.
    v3_in_x = vecs[0].x; v3_in_y = vecs[0].y; v3_in_desc = vecs[0].desc; v3_in_valid = 1'b1;
    @(posedge clk); #1;
    v3_in_valid = 1'b0;
    wait_v3(lat);
    chk("bp out_valid", 128'(v3_out_valid), 128'(1));
    hold_x = v3_out_x; hold_y = v3_out_y; hold_perm = v3_out_perm;
    chk("bp out_y", 128'(hold_y), 128'(vecs[0].ey));
    v3_in_x = vecs[2].x; v3_in_y = vecs[2].y; v3_in_desc = 1'b0; v3_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp stable out_y", 128'(v3_out_y), 128'(vecs[0].ey));
      chk("bp stable out_x", 128'(v3_out_x), 128'(hold_x));
      chk("bp stable out_perm", 128'(v3_out_perm), 128'(hold_perm));
      chk("bp in_ready low", 128'(v3_in_ready), 128'(0));
      chk("bp out_valid held", 128'(v3_out_valid), 128'(1));
    end
    v3_out_ready = 1'b1;
    @(posedge clk); #1;
    v3_out_ready = 1'b0;
    chk("bp release in_ready", 128'(v3_in_ready), 128'(1));
    chk("bp release busy", 128'(v3_busy), 128'(0));
    chk("bp release out_valid", 128'(v3_out_valid), 128'(0));
    v3_in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset one cycle into SORT drops the primitive.
    v3_in_x = vecs[3].x; v3_in_y = vecs[3].y; v3_in_desc = vecs[3].desc; v3_in_valid = 1'b1;
    @(posedge clk); #1;
    v3_in_valid = 1'b0;
    chk("midsort busy", 128'(v3_busy), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midsort rst out_valid", 128'(v3_out_valid), 128'(0));
    chk("midsort rst in_ready", 128'(v3_in_ready), 128'(1));
    chk("midsort rst busy", 128'(v3_busy), 128'(0));
    chk("midsort rst out_y", 128'(v3_out_y), 128'(0));
    chk("midsort rst out_flat", 128'(v3_out_flat), 128'(1));
    run3(vecs[4], "after_rst");

    // Eight vertices, 12-bit coordinates.
    v8_in_desc = 1'b0; v8_in_valid = 1'b1;
    @(posedge clk); #1;
    v8_in_valid = 1'b0; v8_in_y = '0;
    lat = 1;
    while (!v8_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n8 latency", 128'(lat), 128'(8));
    chk("n8 out_y", 128'(v8_out_y), 128'(exp8_y));
    chk("n8 out_x", 128'(v8_out_x), 128'(exp8_x));
    chk("n8 out_perm", 128'(v8_out_perm), 128'(exp8_perm));
    chk("n8 out_flat", 128'(v8_out_flat), 128'(0));
    v8_out_ready = 1'b1;
    @(posedge clk); #1;
    v8_out_ready = 1'b0;
    chk("n8 in_ready after ready", 128'(v8_in_ready), 128'(1));

    // Single vertex goes straight to DONE.
    v1_in_valid = 1'b1;
    @(posedge clk); #1;
    v1_in_valid = 1'b0;
    chk("n1 out_valid at T+1", 128'(v1_out_valid), 128'(1));
    chk("n1 out_y", 128'(v1_out_y), 128'(16'hFFF9));
    chk("n1 out_x", 128'(v1_out_x), 128'(16'd9));
    chk("n1 out_perm", 128'(v1_out_perm), 128'(0));
    chk("n1 out_flat", 128'(v1_out_flat), 128'(1));
    v1_out_ready = 1'b1;
    @(posedge clk); #1;
    v1_out_ready = 1'b0;
    chk("n1 in_ready after ready", 128'(v1_in_ready), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
